// File: rtl/pattern_tx_1011.sv
// pattern_tx_1011: repeats a fixed pattern MSB first N times with zero gaps, valid/ready request, done pulse.
// Define PAT_PROG_EN to take the pattern from the runtime pattern_in port instead of PATTERN.
module pattern_tx_1011 #(
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int GAP = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
`ifdef PAT_PROG_EN
  input  logic [PAT_W-1:0] pattern_in,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [PAT_W-1:0] pat_q, pat_d, pat_src;
  logic out_q, out_d, out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
`ifdef PAT_PROG_EN
  assign pat_src = pattern_in;
`else
  assign pat_src = PATTERN;
`endif
  assign req_ready = (state_q == S_IDLE) & ~rst;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    idx_d = idx_q;
    gcnt_d = gcnt_q;
    pat_d = pat_q;
    unique case (state_q)
      S_IDLE: if (req_valid && req_ready) begin
        rem_d = req_count;
        pat_d = pat_src;
        idx_d = IDX_TOP;
        state_d = (req_count != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: if (idx_q == '0) begin
        rem_d = rem_q - 1'b1;
        idx_d = IDX_TOP;
        gcnt_d = 4'(GAP);
        state_d = (rem_q == CNT_W'(1)) ? S_DONE : (GAP > 0 ? S_GAP : S_SHIFT);
      end else begin
        idx_d = idx_q - 1'b1;
      end
      S_GAP: begin
        gcnt_d = gcnt_q - 1'b1;
        idx_d = IDX_TOP;
        state_d = (gcnt_q == 4'd1) ? S_SHIFT : S_GAP;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // outputs are decoded from the next state so they line up with the state register
    out_d = (state_d == S_SHIFT) & pat_d[idx_d];
    out_valid_d = (state_d == S_SHIFT) | (state_d == S_GAP);
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q <= '0;
      idx_q <= '0;
      gcnt_q <= '0;
      pat_q <= '0;
      out_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      gcnt_q <= gcnt_d;
      pat_q <= pat_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pattern_tx_1011.sv
// tb_pattern_tx_1011: default (GAP=2) and GAP=0 instances checked against a bit-stream model.
module tb_pattern_tx_1011;
  typedef bit bq_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv = 1'b0;
  logic sel = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic [3:0] pin = 4'b1011;
  logic rr0, o0, ov0, b0, d0, rr1, o1, ov1, b1, d1;
  logic rdy, o, ov, bz, dn;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pattern_tx_1011 dut0 (
    .clk(clk), .rst(rst), .req_valid(rv & ~sel), .req_ready(rr0), .req_count(cnt),
`ifdef PAT_PROG_EN
    .pattern_in(pin),
`endif
    .out(o0), .out_valid(ov0), .busy(b0), .done(d0));
  pattern_tx_1011 #(.GAP(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv & sel), .req_ready(rr1), .req_count(cnt),
`ifdef PAT_PROG_EN
    .pattern_in(pin),
`endif
    .out(o1), .out_valid(ov1), .busy(b1), .done(d1));
  assign rdy = sel ? rr1 : rr0;
  assign o = sel ? o1 : o0;
  assign ov = sel ? ov1 : ov0;
  assign bz = sel ? b1 : b0;
  assign dn = sel ? d1 : d0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // N copies of the pattern, MSB first, with g zeros between copies and none after the last
  function automatic bq_t model(input int n, input int g, input logic [3:0] p);
    bq_t q;
    for (int r = 0; r < n; r++) begin
      for (int j = 3; j >= 0; j--) q.push_back(p[j]);
      if (r < n - 1) repeat (g) q.push_back(1'b0);
    end
    return q;
  endfunction
  task automatic xfer(input bit s, input int n, input int poke, input bit prog);
    bq_t q;
    logic [3:0] p;
    p = pin;
    q = model(n, s ? 0 : 2, p);
    sel = s;
    @(negedge clk);
    chk("ready_pre", rdy, 1);
    rv = 1'b1;
    cnt = n[7:0];
    foreach (q[i]) begin
      @(negedge clk);
      rv = (i == poke);
      if (i == poke) cnt = 8'd1;
      if (prog && i == 0) pin = ~p;
      chk("out_valid", ov, 1);
      chk("out", o, q[i]);
      chk("busy", bz, 1);
      chk("done_early", dn, 0);
      chk("ready_busy", rdy, 0);
    end
    @(negedge clk);
    rv = 1'b0;
    chk("done", dn, 1);
    chk("ov_done", ov, 0);
    chk("busy_done", bz, 1);
    @(negedge clk);
    chk("ready_post", rdy, 1);
    chk("done_once", dn, 0);
    chk("busy_idle", bz, 0);
  endtask
  initial begin
    bq_t q;
    rv = 1'b1;
    cnt = 8'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", {rr0, rr1}, 0);
      chk("rst_ov", {ov0, ov1}, 0);
      chk("rst_busy", {b0, b1}, 0);
      chk("rst_done", {d0, d1}, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rv = 1'b0;
    #1 chk("ready_after_rst", {rr0, rr1}, 2'b11);
    @(negedge clk);
    chk("idle_after_rst", {ov0, ov1, b0, b1, o0, o1}, 0);
    xfer(0, 2, -1, 0);
    xfer(0, 0, -1, 0);
    xfer(1, 3, -1, 0);
    xfer(0, 5, 9, 0);
    xfer(1, 5, 3, 0);
    q = model(5, 2, pin);
    sel = 1'b0;
    @(negedge clk);
    rv = 1'b1;
    cnt = 8'd5;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rv = 1'b0;
      chk("abort_out", {ov, o}, {1'b1, q[i]});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ov", ov, 0);
    chk("abort_busy", bz, 0);
    chk("abort_done", dn, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {dn, ov, bz}, 0);
    end
    chk("abort_ready", rdy, 1);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 40)), 0);
    end
    xfer(1, 255, -1, 0);
`ifdef PAT_PROG_EN
    pin = 4'b1100;
    xfer(0, 1, -1, 1);
    pin = 4'b1011;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_tx_1011.md
# pattern_tx_1011

Serial pattern transmitter: the transmit-side counterpart of the team's serial sequence detectors. On each accepted request it emits a fixed bit pattern, MSB first, a requested number of times, with a zero-filled gap between repetitions. It drives detector inputs in loopback benches and feeds serial test links in the datapath. It uses a valid/ready request handshake and reports completion with a one-cycle `done` pulse.

## Interface
- `PAT_W`, default 4: pattern length in bits, 2..16.
- `PATTERN`, default 4'b1011: pattern transmitted, MSB first.
- `GAP`, default 2: number of zero bits inserted between repetitions, 0..15.
- `CNT_W`, default 8: width of the repetition count.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_count`  in  CNT_W  number of repetitions.
- `pattern_in`  in  PAT_W  runtime pattern; exists only with `PAT_PROG_EN`.
- `out`  out  1  serial data bit.
- `out_valid`  out  1  `out` carries a transmitted bit, pattern or gap.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE
  - SHIFT: pattern bits.
  - GAP: zero fill.
  - DONE
- Registers:
  - `rem`: CNT_W, repetitions left.
  - `idx`: bit index, clog2(PAT_W) bits.
  - `gcnt`: gap counter, 4 bits.
  - `pat`: PAT_W, latched pattern.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `req_count` into `rem` and the pattern into `pat`.
  - If count > 0, go to SHIFT with `idx`=PAT_W-1.
  - If count == 0, go to DONE.
- SHIFT:
  - `out`=`pat[idx]`, `out_valid`=1.
  - Decrement `idx` each cycle.
  - At `idx`==0, decrement `rem`.
  - If the new `rem` == 0, go to DONE.
  - Otherwise, if GAP>0, go to GAP with `gcnt`=GAP.
  - Otherwise, go to SHIFT with `idx`=PAT_W-1. Repetitions are then back to back.
- GAP:
  - `out`=0, `out_valid`=1 for exactly GAP cycles.
  - Then go to SHIFT with `idx`=PAT_W-1.
- DONE:
  - `done`=1, `out`=0, `out_valid`=0 for one cycle.
  - Then go to IDLE.
- `busy`=1 in SHIFT, GAP and DONE.
- `req_ready`=1 only in IDLE and only while `rst`=0.
- `req_valid` is ignored outside IDLE. Inputs are not sampled mid-transfer.
- `rem` decrement never underflows; a zero count never enters SHIFT.
- No gap after the final repetition; no leading gap.

## Timing
- While `rst`=1 and in the first cycle after reset:
  - State = IDLE.
  - `out`=0, `out_valid`=0, `busy`=0, `done`=0.
  - `req_ready`=0 while `rst`=1, and 1 from the first cycle with `rst`=0.
- `out`, `out_valid`, `busy` and `done` are registered, decoded from the current state. `req_ready` = (state==IDLE) & ~`rst`.
- Accept on edge E. The first pattern bit is valid in the cycle after E (latency 1).
- `out_valid` stays high continuously for N·PAT_W + (N-1)·GAP cycles, where N = `req_count` > 0.
- `done` occurs in the cycle immediately after the last valid bit.
- `req_ready` returns in the cycle after `done`. The minimum request spacing is the transfer length + 2 cycles.
- `req_count`=0: `done` occurs in the cycle after E; `out_valid` never asserts.
- `rst` asserted mid-transfer: on the next edge, abort to IDLE with all outputs at reset values. No `done` pulse is produced for the aborted request.
- `rst` and `req_valid` high together: reset wins; the request is not accepted.
- A maximum count (2^CNT_W−1) must complete without wrap.

## Configuration
- `PAT_PROG_EN` defined:
  - Port `pattern_in` exists.
  - `pat` latches `pattern_in` at accept.
  - Changes to `pattern_in` during a transfer have no effect.
- `PAT_PROG_EN` undefined:
  - Port `pattern_in` is absent.
  - `pat` is loaded from parameter `PATTERN` at accept.
  - Behaviour is otherwise identical.

## Test plan
All scenarios use default parameters unless noted.
- Reset with `req_valid`=1:
  - While `rst`=1: `req_ready`=0, `out_valid`=0, `busy`=0.
  - First cycle after `rst` falls: `req_ready`=1.
- `req_count`=2 accepted at edge E:
  - `out` sequence 1,0,1,1,0,0,1,0,1,1 over 10 consecutive cycles, with `out_valid`=1 throughout.
  - `done`=1 in cycle 11; `req_ready`=1 in cycle 12.
- `req_count`=0:
  - `out_valid` stays 0.
  - `done`=1 in the cycle after accept, then IDLE.
- GAP=0, `req_count`=3:
  - 12 contiguous valid bits: 1011 1011 1011.
  - `done` follows immediately.
- Mid-transfer hazards, `req_count`=5:
  - `req_valid` pulsed during the transfer is ignored and the count stays 5.
  - Assert `rst` at bit 7: the next cycle has `out_valid`=0 and `busy`=0, and no `done` pulse occurs.
- `PAT_PROG_EN`, `pattern_in`=4'b1100, `req_count`=1:
  - `out` = 1,1,0,0.
  - Changing `pattern_in` to 4'b0011 after accept leaves the output unchanged.
